ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency.
REQ-002 SHALL have parameter INHIBIT_US, default 120, clock-inhibit time before the start bit.
REQ-003 SHALL have parameter START_TIMEOUT_US, default 15000, maximum wait for the first device clock edge.
REQ-004 SHALL have parameter XFER_TIMEOUT_US, default 2000, maximum time from first device edge to ack.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port PS2_CLK, inout, 1 bit: PS/2 clock, open-drain (drives 0 or Z only).
REQ-008 SHALL have port PS2_DAT, inout, 1 bit: PS/2 data, open-drain (drives 0 or Z only).
REQ-009 SHALL have port tx_data, input, 8 bits: command byte to the device.
REQ-010 SHALL have port tx_valid, input, 1 bit: request to send tx_data.
REQ-011 SHALL have port tx_ready, output, 1 bit: high in IDLE only.
REQ-012 SHALL have port tx_done, output, 1 bit: one-cycle pulse on acknowledged completion.
REQ-013 SHALL have port tx_error, output, 1 bit: one-cycle pulse on timeout or missing ack.
REQ-014 SHALL have port busy, output, 1 bit: high whenever not in IDLE, so receivers can ignore bus activity.

Function
REQ-015 SHALL accept a byte when tx_valid && tx_ready on a rising clk edge, latching tx_data and computing odd parity (bit = ~^data); tx_valid while not ready is ignored.
REQ-016 SHALL sequence IDLE -> INHIBIT -> START -> XFER -> ACK -> WAIT_REL -> IDLE, with any fault going to ERROR -> IDLE.
REQ-017 INHIBIT SHALL drive PS2_CLK low for INHIBIT_US*CLK_FREQ_HZ/1e6 cycles (6000 at default), releasing PS2_DAT.
REQ-018 START SHALL drive PS2_DAT low, release PS2_CLK, and wait for the first synchronized PS2_CLK falling edge.
REQ-019 XFER SHALL count device falling edges: after edges 1-8, drive bit[edge-1] (LSB first); after edge 9, drive parity; after edge 10, release PS2_DAT (stop bit).
REQ-020 ACK SHALL sample synchronized PS2_DAT at falling edge 11; low means ack, high means error.
REQ-021 WAIT_REL SHALL wait until both synchronized lines are high, then pulse tx_done and return to IDLE.
REQ-022 In every data position, "drive 1" SHALL mean release (Z).
REQ-023 ERROR SHALL release both lines, pulse tx_error for one cycle, and return to IDLE.
REQ-024 PS2_CLK and PS2_DAT inputs SHALL pass through 2-flop synchronizers; falling-edge detection SHALL use the synchronized clock (latency 2-3 cycles).
REQ-025 The edge counter SHALL be 4 bits and saturate at 11.
REQ-026 Timers SHALL be wide enough for the largest parameterized count.

Reset
REQ-027 On reset_n low, the block SHALL asynchronously enter IDLE, release both lines, and set tx_ready=1, tx_done=0, tx_error=0, busy=0, with counters and shift register cleared.
REQ-028 Reset mid-transfer SHALL abort without a tx_done or tx_error pulse.

Configuration
REQ-029 With macro PS2_HOST_TX_TIMEOUT_EN defined, START SHALL go to ERROR after START_TIMEOUT_US, and XFER/ACK after XFER_TIMEOUT_US measured from edge 1.
REQ-030 Without PS2_HOST_TX_TIMEOUT_EN, no timeout counters SHALL exist, and only a missing ack asserts tx_error.

Structure
REQ-031 A shared package ps2_pkg SHALL hold the state enumeration, the us-to-cycles conversion constant function, and PS/2 frame constants (11 edges, odd parity).
REQ-032 Synchronizer plus falling-edge detector SHALL be the sub-module ps2_line_sync, instantiated once per line.

Verification
REQ-033 Send 0xF4 with a device model acknowledging -> PS2_CLK low for 6000 cycles; data bits 0,0,1,0,1,1,1,1; parity 0; stop released; tx_done pulse; busy falls.
REQ-034 Send 0xED -> parity 1; next send 0x00 -> parity 1; both get tx_done.
REQ-035 Device model holds PS2_DAT high at edge 11 -> tx_error pulse, no tx_done, both lines released.
REQ-036 With the timeout macro defined, device never clocks -> tx_error after 750000 cycles in START. Without it -> the block remains in START.
REQ-037 Assert reset_n low during edge 5 -> lines released next cycle, tx_ready=1, no pulses.
REQ-038 tx_valid held high during a transfer with changing tx_data -> only the first byte is sent; the second is accepted only after return to IDLE.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host-to-device transmitter.
//   ps2_state_t  : transmitter state enumeration
//   us_to_cycles : converts a time in microseconds to system clock cycles
//   FRAME_EDGES  : device clock falling edges in one host-to-device frame
//   PARITY_EDGE  : edge after which the parity bit is presented
//   STOP_EDGE    : edge after which the stop bit (released line) is presented
//   odd_parity   : parity bit that makes the 9-bit data+parity field odd
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_XFER,
        ST_ACK,
        ST_WAIT_REL,
        ST_ERROR
    } ps2_state_t;

    localparam logic [3:0] FRAME_EDGES = 4'd11;
    localparam logic [3:0] PARITY_EDGE = 4'd9;
    localparam logic [3:0] STOP_EDGE   = 4'd10;

    // 64-bit intermediate: 15000 us * 50 MHz does not fit in 32 bits.
    function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned us);
        longint unsigned c;
        c = (64'(clk_hz) * 64'(us)) / 64'd1_000_000;
        return 32'(c);
    endfunction

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync -- two-flop synchronizer plus falling-edge detector for one
// PS/2 line. Flops reset to 1, the idle level of an open-drain line.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   line    : raw PS/2 line (asynchronous)
//   level   : synchronized line level
//   fall    : one-cycle pulse when the synchronized level goes 1 -> 0
module ps2_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic line,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= line;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
// Inhibits the bus, issues a start condition, shifts out 8 data bits (LSB
// first), odd parity and a stop bit on device clock falling edges, then
// checks the device acknowledge bit.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   PS2_CLK  : PS/2 clock, open-drain (drives 0 or Z)
//   PS2_DAT  : PS/2 data, open-drain (drives 0 or Z)
//   tx_data  : command byte, latched when tx_valid && tx_ready
//   tx_valid : send request
//   tx_ready : high in IDLE only
//   tx_done  : one-cycle pulse on acknowledged completion
//   tx_error : one-cycle pulse on missing ack (or timeout, see below)
//   busy     : high whenever not in IDLE
// Build option: define PS2_HOST_TX_TIMEOUT_EN to abort to ERROR when the
// device does not start clocking within START_TIMEOUT_US, or does not finish
// the frame within XFER_TIMEOUT_US of its first edge.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
    parameter int unsigned INHIBIT_US       = 120,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned XFER_TIMEOUT_US  = 2000
) (
    input  logic       clk,
    input  logic       reset_n,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy
);

    localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
    localparam int unsigned START_CYC   = us_to_cycles(CLK_FREQ_HZ, START_TIMEOUT_US);
    localparam int unsigned XFER_CYC    = us_to_cycles(CLK_FREQ_HZ, XFER_TIMEOUT_US);
    // One shared timer, sized for every configurable interval so both
    // builds keep the same register layout.
    localparam int unsigned MAX_AB    = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
    localparam int unsigned TIMER_MAX = (MAX_AB > XFER_CYC) ? MAX_AB : XFER_CYC;
    localparam int          TIMER_W   = $clog2(TIMER_MAX + 1);

    ps2_state_t         state;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         edge_cnt;
    logic [7:0]         shift;
    logic               parity;
    logic               clk_low;
    logic               dat_low;

    logic clk_s;
    logic clk_fall;
    logic dat_s;
    logic dat_fall_unused;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .line    (PS2_CLK),
        .level   (clk_s),
        .fall    (clk_fall)
    );

    ps2_line_sync u_dat_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .line    (PS2_DAT),
        .level   (dat_s),
        .fall    (dat_fall_unused)
    );

    assign PS2_CLK  = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT  = dat_low ? 1'b0 : 1'bz;
    assign tx_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    function automatic logic [3:0] edge_inc(input logic [3:0] c);
        return (c >= FRAME_EDGES) ? FRAME_EDGES : c + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            timer    <= '0;
            edge_cnt <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            clk_low  <= 1'b0;
            dat_low  <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    clk_low <= 1'b0;
                    dat_low <= 1'b0;
                    if (tx_valid) begin
                        shift    <= tx_data;
                        parity   <= odd_parity(tx_data);
                        edge_cnt <= '0;
                        timer    <= '0;
                        clk_low  <= 1'b1;
                        state    <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (timer == TIMER_W'(INHIBIT_CYC - 1)) begin
                        // Data goes low as the clock is released: start condition.
                        clk_low <= 1'b0;
                        dat_low <= 1'b1;
                        timer   <= '0;
                        state   <= ST_START;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_START: begin
`ifdef PS2_HOST_TX_TIMEOUT_EN
                    if (timer == TIMER_W'(START_CYC - 1)) begin
                        state <= ST_ERROR;
                    end else
`endif
                    if (clk_fall) begin
                        // Edge 1: present bit 0 and start the transfer window.
                        edge_cnt <= 4'd1;
                        dat_low  <= ~shift[0];
                        shift    <= shift >> 1;
                        timer    <= '0;
                        state    <= ST_XFER;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_XFER: begin
`ifdef PS2_HOST_TX_TIMEOUT_EN
                    if (timer == TIMER_W'(XFER_CYC - 1)) begin
                        state <= ST_ERROR;
                    end else
`endif
                    begin
                        timer <= timer + TIMER_W'(1);
                        if (clk_fall) begin
                            edge_cnt <= edge_inc(edge_cnt);
                            // edge_cnt holds the previous edge number here.
                            if (edge_cnt < PARITY_EDGE - 4'd1) begin
                                dat_low <= ~shift[0];
                                shift   <= shift >> 1;
                            end else if (edge_cnt == PARITY_EDGE - 4'd1) begin
                                dat_low <= ~parity;
                            end else if (edge_cnt == STOP_EDGE - 4'd1) begin
                                dat_low <= 1'b0;
                                state   <= ST_ACK;
                            end
                        end
                    end
                end
                ST_ACK: begin
`ifdef PS2_HOST_TX_TIMEOUT_EN
                    if (timer == TIMER_W'(XFER_CYC - 1)) begin
                        state <= ST_ERROR;
                    end else
`endif
                    begin
                        timer <= timer + TIMER_W'(1);
                        if (clk_fall) begin
                            edge_cnt <= edge_inc(edge_cnt);
                            state    <= dat_s ? ST_ERROR : ST_WAIT_REL;
                        end
                    end
                end
                ST_WAIT_REL: begin
                    if (clk_s && dat_s) begin
                        tx_done <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    clk_low  <= 1'b0;
                    dat_low  <= 1'b0;
                    tx_error <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- directed bench for ps2_host_tx with a PS/2 device model
// on pulled-up open-drain lines. Follows the PS2_HOST_TX_TIMEOUT_EN build
// option for the stalled-device case.
module tb_ps2_host_tx;

    localparam int HALF        = 20;    // device clock half period, system cycles
    localparam int INHIBIT_CYC = 6000;  // 120 us at 50 MHz
    localparam int START_CYC   = 5000;  // 100 us at 50 MHz

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       busy;

    wire  ps2_clk;
    wire  ps2_dat;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    ps2_host_tx #(
        .CLK_FREQ_HZ      (50_000_000),
        .INHIBIT_US       (120),
        .START_TIMEOUT_US (100),
        .XFER_TIMEOUT_US  (2000)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .tx_error (tx_error),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int n_err    = 0;

    always @(negedge clk) begin
        if (tx_done === 1'b1)  n_done++;
        if (tx_error === 1'b1) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device model: measures the inhibit, clocks 11 edges, samples each
    // host bit late in the clock-low phase, optionally acknowledges, and can
    // pulse reset during a chosen edge.
    task automatic dev_frame(input bit ack, input int abort_edge,
                             output int inh, output logic startb,
                             output logic [7:0] got, output logic par,
                             output logic stp);
        int n = 0;
        inh = 0; got = 8'h00; par = 1'b0; stp = 1'b0; startb = 1'b1;
        while (ps2_clk !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (ps2_clk === 1'b0 && inh < 20000) begin
            inh++;
            @(negedge clk);
        end
        startb = ps2_dat;
        for (int e = 1; e <= 11; e++) begin
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            if (e == abort_edge) begin
                repeat (HALF / 2) @(negedge clk);
                check("abort_bit_driven", ps2_dat, 0);
                reset_n     = 1'b0;
                dev_clk_low = 1'b0;
                @(negedge clk);
                check("abort_clk_rel", ps2_clk, 1);
                check("abort_dat_rel", ps2_dat, 1);
                check("abort_ready", tx_ready, 1);
                check("abort_busy", busy, 0);
                reset_n = 1'b1;
                return;
            end
            repeat (HALF - 1) @(negedge clk);
            if (e <= 8) got[e-1] = ps2_dat;
            else if (e == 9) par = ps2_dat;
            else if (e == 10) begin
                stp = ps2_dat;
                if (ack) dev_dat_low = 1'b1;
            end
            @(negedge clk);
            dev_clk_low = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        dev_dat_low = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    initial begin
        int         inh;
        logic       sb;
        logic [7:0] got;
        logic       par;
        logic       stp;
        int         d0;
        int         e0;
        int         cnt;
        vec_t       vecs[3];
        vecs[0] = '{8'hF4, 1'b0};
        vecs[1] = '{8'hED, 1'b1};
        vecs[2] = '{8'h00, 1'b1};

        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        check("rst_clk", ps2_clk, 1);
        check("rst_dat", ps2_dat, 1);

        // Acknowledged frames
        foreach (vecs[i]) begin
            d0 = n_done; e0 = n_err;
            send(vecs[i].data);
            dev_frame(1'b1, 0, inh, sb, got, par, stp);
            check("ack_inhibit", inh, INHIBIT_CYC);
            check("ack_start", sb, 0);
            check("ack_byte", got, vecs[i].data);
            check("ack_parity", par, vecs[i].par);
            check("ack_stop", stp, 1);
            check("ack_done", n_done - d0, 1);
            check("ack_err", n_err - e0, 0);
            check("ack_busy", busy, 0);
            check("ack_ready", tx_ready, 1);
        end

        // No acknowledge
        d0 = n_done; e0 = n_err;
        send(8'h55);
        dev_frame(1'b0, 0, inh, sb, got, par, stp);
        check("nack_byte", got, 8'h55);
        check("nack_parity", par, 1);
        check("nack_err", n_err - e0, 1);
        check("nack_done", n_done - d0, 0);
        check("nack_clk", ps2_clk, 1);
        check("nack_dat", ps2_dat, 1);
        check("nack_ready", tx_ready, 1);

        // Reset during edge 5 (bit 4 of 0x0F is 0, so data is driven low)
        d0 = n_done; e0 = n_err;
        send(8'h0F);
        dev_frame(1'b1, 5, inh, sb, got, par, stp);
        repeat (50) @(negedge clk);
        check("abort_no_done", n_done - d0, 0);
        check("abort_no_err", n_err - e0, 0);
        check("abort_idle_ready", tx_ready, 1);

        // tx_valid held through a transfer while tx_data changes
        d0 = n_done;
        while (tx_ready !== 1'b1) @(negedge clk);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        check("hold_busy", busy, 1);
        tx_data = 8'h3C;
        dev_frame(1'b1, 0, inh, sb, got, par, stp);
        check("hold_first", got, 8'hA5);
        check("hold_first_done", n_done - d0, 1);
        check("hold_second_taken", busy, 1);
        tx_valid = 1'b0;
        dev_frame(1'b1, 0, inh, sb, got, par, stp);
        check("hold_second", got, 8'h3C);
        check("hold_second_done", n_done - d0, 2);

        // Device never clocks
        e0 = n_err;
        send(8'h11);
        cnt = 0;
        while (ps2_clk !== 1'b0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        while (ps2_clk === 1'b0 && cnt < 20000) begin
            @(negedge clk);
            cnt++;
        end
`ifdef PS2_HOST_TX_TIMEOUT_EN
        cnt = 0;
        while (tx_error !== 1'b1 && cnt < START_CYC + 100) begin
            @(negedge clk);
            cnt++;
        end
        check("to_cycles", cnt, START_CYC + 1);
        @(negedge clk);
        check("to_err", n_err - e0, 1);
        check("to_clk", ps2_clk, 1);
        check("to_dat", ps2_dat, 1);
        check("to_ready", tx_ready, 1);
`else
        repeat (START_CYC + 1000) @(negedge clk);
        check("stall_busy", busy, 1);
        check("stall_dat", ps2_dat, 0);
        check("stall_clk", ps2_clk, 1);
        check("stall_err", n_err - e0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("stall_reset_ready", tx_ready, 1);
        check("stall_reset_dat", ps2_dat, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout, want summary");
        $fatal(1);
    end

endmodule
